sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between three bus masters (0 = instruction fetch, 1 = data, 2 = video/blitter).
- Performs round-robin arbitration and drives the controller's one-hot master select with the muxed request fields.
- Routes ack and completion back to the owning master; read data and valid are routed per master.
- Sits between the bus masters and the SDRAM controller, in the same clock domain.

Parameters:
ADDR_W, 26, byte address width passed to the controller
OWNER_DEPTH, 4, read-owner FIFO depth (power of 2, >= 4)

Ports:
clock  in  1  system clock, 100 MHz
reset  in  1  reset; one clock; reset is synchronous and active-high
master_req  in  3  per-master request; held until the matching master_ack
master_addr  in  3*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
master_write  in  3  1 = write
master_burst  in  3  1 = burst read (ignored for writes)
master_byte_enable  in  12  4 bits per master
master_wdata  in  96  32 bits per master
master_ack  out  3  one-hot; request accepted this cycle
master_rdata  out  32  read data, broadcast to all masters
master_rdvalid  out  3  one-hot; master_rdata valid for that master
master_complete  out  3  one-hot; that master's read transaction finished
sdram_req  out  3  one-hot master select to the controller
sdram_addr  out  ADDR_W  muxed field
sdram_write  out  1  muxed field
sdram_burst  out  1  muxed field
sdram_byte_enable  out  4  muxed field
sdram_wdata  out  32  muxed field
sdram_ack  in  1  controller accepted the request (combinational from the controller)
sdram_rdata  in  32  controller read data
sdram_rdvalid  in  3  controller read valid, tagged with the master
sdram_complete  in  1  controller finished the oldest outstanding read

Behaviour:
- State machine states: IDLE, GRANT, BURST_WAIT. Registers: state, grant (2-bit index), rr_last (2-bit), owner FIFO (OWNER_DEPTH x 2 bits plus count).
- Reset values:
  - state = IDLE, rr_last = 2 (master 0 wins first), FIFO empty.
  - All outputs 0; muxed sdram_* fields = 0.
- IDLE:
  - If any master_req bit is set and the FIFO is not full, pick the winner: the first requesting index after rr_last, modulo 3.
  - Register the winner into grant, set rr_last = winner, go to GRANT.
  - A read request while the FIFO is full is not granted; a write request is still eligible.
- GRANT:
  - sdram_req = onehot(grant); sdram_* fields are muxed from master[grant].
  - In every other state, sdram_req = 0 and the fields are 0.
  - When sdram_ack = 1: master_ack = onehot(grant) combinationally in the same cycle.
  - After that ack: a read pushes grant into the FIFO.
  - Next state after the ack: BURST_WAIT if it was a burst read, otherwise IDLE.
  - While sdram_ack = 0, stay in GRANT; the request is never withdrawn or re-arbitrated.
- BURST_WAIT: no grants. Leave for IDLE on the cycle sdram_complete pops the burst's FIFO entry.
- Latency:
  - From master_req rising in IDLE to sdram_req: 1 cycle.
  - From sdram_ack to the next sdram_req: 2 cycles minimum (IDLE re-arbitrates on the cycle after the ack).
- Completion routing:
  - sdram_complete pops the FIFO head; master_complete = onehot(head) in the same cycle.
  - Push and pop in the same cycle leave the count unchanged, and the head stays correct.
  - sdram_complete while the FIFO is empty is ignored (master_complete = 0).
- Read data routing:
  - master_rdvalid = sdram_rdvalid, combinational pass-through.
  - master_rdata = sdram_rdata.
- The master_req bit of the winner must stay stable until its ack. Fields of a non-granted master are don't-care.
- Reset asserted mid-transaction:
  - Takes effect at the next clock edge: state returns to IDLE and the FIFO is cleared.
  - Pending sdram_complete pulses after reset are ignored.

Optional Feature:
- Macro SDRAM_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, master 0 > 1 > 2; rr_last is not used.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset, then master 0 read (addr 0x0000100, burst = 0); sdram_ack on the 2nd GRANT cycle -> sdram_req = 3'b001 from cycle 1; master_ack = 3'b001 on the ack cycle; sdram_complete 4 cycles later -> master_complete = 3'b001.
- All three masters request continuously, controller acks each immediately -> grant order 0,1,2,0,1,2; each sdram_req lasts 1 cycle, with an idle cycle between grants.
- Master 1 burst read, master 2 write pending -> master 2 is not granted until sdram_complete for master 1; master_complete = 3'b010 on that cycle, then sdram_req = 3'b100.
- Two back-to-back single reads (masters 0, 2), then a completion that coincides with the second push -> master_complete = 3'b001, then 3'b100; FIFO empty afterwards.
- Reset asserted while in BURST_WAIT -> next cycle state = IDLE and sdram_req = 0; a subsequent sdram_complete gives master_complete = 0.
- With SDRAM_ARB_FIXED_PRIORITY_EN, masters 1 and 2 requesting continuously -> master 1 is always granted and master 2 is never granted while master 1 requests.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bus bundle joining the three masters and the SDRAM controller through the arbiter.
// Latency: none, wires only.
// Backpressure: carried by master_req/master_ack and sdram_req/sdram_ack inside the bundle.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 26
);
  // master side
  logic [2:0]          master_req;
  logic [3*ADDR_W-1:0] master_addr;
  logic [2:0]          master_write;
  logic [2:0]          master_burst;
  logic [11:0]         master_byte_enable;
  logic [95:0]         master_wdata;
  logic [2:0]          master_ack;
  logic [31:0]         master_rdata;
  logic [2:0]          master_rdvalid;
  logic [2:0]          master_complete;
  // controller side
  logic [2:0]          sdram_req;
  logic [ADDR_W-1:0]   sdram_addr;
  logic                sdram_write;
  logic                sdram_burst;
  logic [3:0]          sdram_byte_enable;
  logic [31:0]         sdram_wdata;
  logic                sdram_ack;
  logic [31:0]         sdram_rdata;
  logic [2:0]          sdram_rdvalid;
  logic                sdram_complete;

  // arbiter view
  modport slave (
    input  master_req, master_addr, master_write, master_burst, master_byte_enable, master_wdata,
    output master_ack, master_rdata, master_rdvalid, master_complete,
    output sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_byte_enable, sdram_wdata,
    input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
  );

  // environment view: masters plus controller
  modport master (
    output master_req, master_addr, master_write, master_burst, master_byte_enable, master_wdata,
    input  master_ack, master_rdata, master_rdvalid, master_complete,
    input  sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_byte_enable, sdram_wdata,
    output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port among 3 masters; round robin by default,
// fixed priority 0 > 1 > 2 when SDRAM_ARB_FIXED_PRIORITY_EN is defined.
// Latency: req -> sdram_req 1 cycle; ack -> next sdram_req >= 2 cycles.
// Backpressure: a grant is held until sdram_ack; reads are not granted while the owner FIFO is full.

// Small FIFO with a combinational head; pop on empty is ignored.
module sdram_arb_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointer and occupancy tracking; simultaneous push+pop keeps the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end
endmodule

module sdram_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int OWNER_DEPTH = 4
) (
  input logic            clock,
  input logic            reset,
  sdram_arbiter_if.slave bus
);
  localparam int CW = $clog2(OWNER_DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    BURST_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        winner;
  logic [2:0]        elig;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_head;
  logic [CW:0]       fifo_count;
  logic [ADDR_W-1:0] g_addr;
  logic              g_write;
  logic              g_burst;
  logic [3:0]        g_be;
  logic [31:0]       g_wdata;

  // Owner FIFO records which master each outstanding read belongs to.
  sdram_arb_fifo #(
    .W     (2),
    .DEPTH (OWNER_DEPTH)
  ) u_owner_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (fifo_push),
    .push_dat_i (grant_q),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // A master may be granted if requesting; reads additionally need owner FIFO room.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 3; i++) begin
      elig[i] = bus.master_req[i] && (bus.master_write[i] || !fifo_full);
    end
  end

  // Request fields of the currently granted master.
  always_comb begin
    g_addr  = '0;
    g_write = 1'b0;
    g_burst = 1'b0;
    g_be    = '0;
    g_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q == 2'(i)) begin
        g_addr  = bus.master_addr[i*ADDR_W +: ADDR_W];
        g_write = bus.master_write[i];
        g_burst = bus.master_burst[i];
        g_be    = bus.master_byte_enable[i*4 +: 4];
        g_wdata = bus.master_wdata[i*32 +: 32];
      end
    end
  end

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    winner = 2'd2;
    if (elig[0])      winner = 2'd0;
    else if (elig[1]) winner = 2'd1;
  end
`else
  logic [1:0] rr_last_q;

  // Round robin: first eligible index after the last winner, wrapping modulo 3.
  always_comb begin
    winner = 2'd0;
    case (rr_last_q)
      2'd0:    winner = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
      2'd1:    winner = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
      default: winner = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Remember the last winner; reset value 2 lets master 0 win first.
  always_ff @(posedge clock) begin
    if (reset)                           rr_last_q <= 2'd2;
    else if (state_q == IDLE && |elig)   rr_last_q <= winner;
  end
`endif

  // FSM state and grant registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // FSM next state plus controller-side drive and master ack.
  always_comb begin
    state_d               = state_q;
    grant_d               = grant_q;
    fifo_push             = 1'b0;
    bus.master_ack        = 3'b000;
    bus.sdram_req         = 3'b000;
    bus.sdram_addr        = '0;
    bus.sdram_write       = 1'b0;
    bus.sdram_burst       = 1'b0;
    bus.sdram_byte_enable = '0;
    bus.sdram_wdata       = '0;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        bus.sdram_req         = 3'b001 << grant_q;
        bus.sdram_addr        = g_addr;
        bus.sdram_write       = g_write;
        bus.sdram_burst       = g_burst;
        bus.sdram_byte_enable = g_be;
        bus.sdram_wdata       = g_wdata;
        if (bus.sdram_ack) begin
          bus.master_ack = 3'b001 << grant_q;
          fifo_push      = !g_write;
          state_d        = (!g_write && g_burst) ? BURST_WAIT : IDLE;
        end
      end
      BURST_WAIT: begin
        // No pushes happen here, so the burst owns the youngest entry: leave when it pops.
        if (fifo_pop && fifo_count == (CW+1)'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop            = bus.sdram_complete && !fifo_empty;
  assign bus.master_complete = fifo_pop ? (3'b001 << fifo_head) : 3'b000;
  assign bus.master_rdvalid  = bus.sdram_rdvalid;
  assign bus.master_rdata    = bus.sdram_rdata;
endmodule
